cpu_run_sequencer: RTL and testbench

- Synthesizable sequencer that drives the CPU core's two-phase clocking (clk phase, then iclk phase) from a simple host command interface.
- Supports single pulses, ticks, and free-running RUN until BRK, HLT, STOP or a cycle limit.
- During RUN it owns the control-word enable and intercepts character output into a ready/valid stream.
- Sits between the host link (serial command decoder) and the cpu instance, replacing host-timed pulse generation.

---
 rtl/cpu_run_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_cpu_run_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_sequencer.sv
// Host-command driven sequencer for the CPU's two-phase (clk, then iclk) clocking:
// single pulses, ticks and free-running RUN with character-output interception.
module cpu_run_sequencer #(
  parameter int CYCLE_W    = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  output logic               cpu_clk_en,
  output logic               cpu_iclk_en,
  output logic               cpu_rst,
  output logic               ctrlen,
  input  logic               brk,
  input  logic               hlt,
  input  logic [7:0]         c_out,
  input  logic               c_out_valid,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_rst,
  output logic               evt_valid,
  output logic [1:0]         evt_code,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               busy
);

  localparam logic [2:0] OP_CLK    = 3'd1;
  localparam logic [2:0] OP_ICLK   = 3'd2;
  localparam logic [2:0] OP_TICK   = 3'd3;
  localparam logic [2:0] OP_RUN    = 3'd4;
  localparam logic [2:0] OP_STOP   = 3'd5;
  localparam logic [2:0] OP_CPURST = 3'd6;

  localparam logic [1:0] EVT_STOP  = 2'd0;
  localparam logic [1:0] EVT_BRK   = 2'd1;
  localparam logic [1:0] EVT_HLT   = 2'd2;
  localparam logic [1:0] EVT_LIMIT = 2'd3;

  localparam logic [CYCLE_W-1:0] LIMIT = CYCLE_W'(MAX_CYCLES);

  typedef enum logic [3:0] {
    IDLE, S_CLK, S_ICLK, T_CLK, T_ICLK, RST_P,
    RUN_CHECK, RUN_CLK, RUN_SAMPLE, RUN_OUT, RUN_ICLK, RUN_END
  } state_t;

  state_t               state_q, state_d;
  logic                 ctrlen_q, ctrlen_d;
  logic [CYCLE_W-1:0]   cycle_count_q, cycle_count_d;
  logic [1:0]           evt_code_q, evt_code_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_rst_q, out_rst_d;
  logic [CYCLE_W-1:0]   count_inc;

  assign count_inc = cycle_count_q + CYCLE_W'(1);

  always_comb begin
    state_d       = state_q;
    ctrlen_d      = ctrlen_q;
    cycle_count_d = cycle_count_q;
    evt_code_d    = evt_code_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_rst_d     = 1'b0;
    cmd_ready     = 1'b0;
    cpu_clk_en    = 1'b0;
    cpu_iclk_en   = 1'b0;
    cpu_rst       = 1'b0;
    evt_valid     = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLK:    state_d = S_CLK;
            OP_ICLK:   state_d = S_ICLK;
            OP_TICK:   state_d = T_CLK;
            OP_CPURST: state_d = RST_P;
            OP_RUN: begin
              state_d       = RUN_CHECK;
              cycle_count_d = '0;
              ctrlen_d      = 1'b0;
            end
            default:   state_d = IDLE;
          endcase
        end
      end
      S_CLK: begin
        cpu_clk_en = 1'b1;
        state_d    = IDLE;
      end
      S_ICLK: begin
        cpu_iclk_en = 1'b1;
        state_d     = IDLE;
      end
      T_CLK: begin
        cpu_clk_en = 1'b1;
        state_d    = T_ICLK;
      end
      T_ICLK: begin
        cpu_iclk_en = 1'b1;
        state_d     = IDLE;
      end
      RST_P: begin
        cpu_rst = 1'b1;
        state_d = IDLE;
      end
      RUN_CHECK: begin
        // STOP is only offered when it would win, so a losing STOP stays pending
        cmd_ready = hlt && !brk && (cmd_op == OP_STOP);
        if (brk) begin
          evt_code_d = EVT_BRK;
          state_d    = RUN_END;
        end else if (!hlt) begin
          evt_code_d = EVT_HLT;
          state_d    = RUN_END;
        end else if (cmd_valid && cmd_op == OP_STOP) begin
          evt_code_d = EVT_STOP;
          state_d    = RUN_END;
        end else begin
          state_d = RUN_CLK;
        end
      end
      RUN_CLK: begin
        cpu_clk_en = 1'b1;
        state_d    = RUN_SAMPLE;
      end
      RUN_SAMPLE: begin
        if (c_out_valid) begin
          out_data_d  = c_out;
          out_valid_d = 1'b1;
          state_d     = RUN_OUT;
        end else begin
          state_d = RUN_ICLK;
        end
      end
      RUN_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_rst_d   = 1'b1;
          state_d     = RUN_ICLK;
        end
      end
      RUN_ICLK: begin
        cpu_iclk_en   = 1'b1;
        cycle_count_d = count_inc;
        if (MAX_CYCLES != 0 && count_inc == LIMIT) begin
          evt_code_d = EVT_LIMIT;
          state_d    = RUN_END;
        end else begin
          state_d = RUN_CHECK;
        end
      end
      RUN_END: begin
        evt_valid = 1'b1;
        ctrlen_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (rst) cmd_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ctrlen_q      <= 1'b1;
      cycle_count_q <= '0;
      evt_code_q    <= EVT_STOP;
      out_data_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      out_rst_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrlen_q      <= ctrlen_d;
      cycle_count_q <= cycle_count_d;
      evt_code_q    <= evt_code_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_rst_q     <= out_rst_d;
    end
  end

  assign ctrlen      = ctrlen_q;
  assign cycle_count = cycle_count_q;
  assign evt_code    = evt_code_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_rst     = out_rst_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer; run events and accepted characters are
// checked against scoreboard queues filled when the stimulus is set up.
module tb_cpu_run_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic        cpu_clk_en, cpu_iclk_en, cpu_rst, ctrlen;
  logic        brk = 1'b0;
  logic        hlt = 1'b1;
  logic [7:0]  c_out = 8'h00;
  logic        c_out_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_rst, evt_valid, busy;
  logic [1:0]  evt_code;
  logic [31:0] cycle_count;

  cpu_run_sequencer #(.CYCLE_W(32), .MAX_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cpu_clk_en(cpu_clk_en), .cpu_iclk_en(cpu_iclk_en),
    .cpu_rst(cpu_rst), .ctrlen(ctrlen), .brk(brk), .hlt(hlt), .c_out(c_out),
    .c_out_valid(c_out_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_rst(out_rst), .evt_valid(evt_valid),
    .evt_code(evt_code), .cycle_count(cycle_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int exp_code_q[$];
  int exp_cnt_q[$];
  logic [7:0] exp_out_q[$];
  int clk_cnt, iclk_cnt, rdy_cnt, pend_cnt;
  bit evt_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Samples the current cycle: strobe counts, handshakes and scoreboard pops
  task automatic mon();
    if (cpu_clk_en === 1'b1) clk_cnt++;
    if (cpu_iclk_en === 1'b1) iclk_cnt++;
    if (busy === 1'b1 && cmd_valid) begin
      if (cmd_ready === 1'b1) rdy_cnt++;
      else pend_cnt++;
    end
    if (evt_valid === 1'b1) begin
      evt_seen = 1'b1;
      if (exp_code_q.size() > 0) begin
        chk("evt_code", evt_code, exp_code_q.pop_front());
        chk("evt_cycle_count", cycle_count, exp_cnt_q.pop_front());
      end else chk("evt_unexpected", evt_valid, 0);
    end
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_out_q.size() > 0) chk("out_data_accept", out_data, exp_out_q.pop_front());
      else chk("out_unexpected", out_valid, 0);
    end
  endtask

  task automatic tick();
    #1;
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    #1;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) tick();
    chk("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_evt();
    for (int i = 0; i < 300 && !evt_seen; i++) tick();
    chk("evt_seen", evt_seen, 1);
  endtask

  initial begin
    // reset
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_ctrlen", ctrlen, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_code", evt_code, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_strobes", {cpu_clk_en, cpu_iclk_en, cpu_rst, out_rst}, 0);

    // TICK
    send(3'd3);
    chk("tick_clk_en", cpu_clk_en, 1);
    chk("tick_iclk_en0", cpu_iclk_en, 0);
    chk("tick_busy0", busy, 1);
    chk("tick_ready0", cmd_ready, 0);
    tick();
    chk("tick_clk_en1", cpu_clk_en, 0);
    chk("tick_iclk_en", cpu_iclk_en, 1);
    chk("tick_busy1", busy, 1);
    chk("tick_ready1", cmd_ready, 0);
    tick();
    chk("tick_idle", busy, 0);

    // single CLK / ICLK / CPURST / op 7
    send(3'd1);
    chk("clk_strobe", {cpu_clk_en, cpu_iclk_en}, 2'b10);
    tick();
    chk("clk_done", busy, 0);
    send(3'd2);
    chk("iclk_strobe", {cpu_clk_en, cpu_iclk_en}, 2'b01);
    tick();
    send(3'd6);
    chk("cpurst_strobe", cpu_rst, 1);
    tick();
    chk("cpurst_done", cpu_rst, 0);
    send(3'd7);
    chk("op7_nop", busy, 0);

    // RUN terminated by brk after 5 iclk strobes
    begin
      int ctrlen_bad = 0;
      iclk_cnt = 0; evt_seen = 0;
      exp_code_q.push_back(1); exp_cnt_q.push_back(5);
      send(3'd4);
      for (int i = 0; i < 300 && !evt_seen; i++) begin
        if (iclk_cnt >= 5) brk = 1'b1;
        if (busy && ctrlen) ctrlen_bad++;
        tick();
      end
      brk = 1'b0;
      chk("brk_evt_seen", evt_seen, 1);
      chk("brk_ctrlen_low_in_run", ctrlen_bad, 0);
      chk("brk_ctrlen_after", ctrlen, 1);
      chk("brk_iclk_count", iclk_cnt, 5);
      chk("brk_count_held", cycle_count, 5);
    end

    // RUN with output stall on the third cycle
    clk_cnt = 0; iclk_cnt = 0; evt_seen = 0;
    exp_out_q.push_back(8'h41);
    send(3'd4);
    for (int i = 0; i < 100 && out_valid !== 1'b1; i++) begin
      c_out_valid = (clk_cnt == 3);
      c_out = (clk_cnt == 3) ? 8'h41 : 8'h00;
      tick();
    end
    c_out_valid = 1'b0;
    c_out = 8'h00;
    chk("stall_iclk_before", iclk_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 8'h41);
      chk("stall_no_strobes", {cpu_clk_en, cpu_iclk_en}, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("accept_out_rst", out_rst, 1);
    chk("accept_iclk", cpu_iclk_en, 1);
    chk("accept_out_valid", out_valid, 0);
    hlt = 1'b0;
    exp_code_q.push_back(2); exp_cnt_q.push_back(3);
    tick();
    chk("out_rst_one_cycle", out_rst, 0);
    wait_evt();
    hlt = 1'b1;
    chk("stall_scoreboard_empty", exp_out_q.size(), 0);

    // RUN to the cycle limit
    iclk_cnt = 0; evt_seen = 0;
    exp_code_q.push_back(3); exp_cnt_q.push_back(10);
    send(3'd4);
    wait_evt();
    chk("limit_iclk_count", iclk_cnt, 10);
    chk("limit_count", cycle_count, 10);

    // STOP raised mid-cycle is held off until RUN_CHECK
    clk_cnt = 0; rdy_cnt = 0; pend_cnt = 0; evt_seen = 0;
    exp_code_q.push_back(0); exp_cnt_q.push_back(2);
    send(3'd4);
    for (int i = 0; i < 300 && !evt_seen; i++) begin
      if (clk_cnt >= 2 && rdy_cnt == 0) begin cmd_valid = 1'b1; cmd_op = 3'd5; end
      tick();
      if (rdy_cnt > 0) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk("stop_evt_seen", evt_seen, 1);
    chk("stop_accepts", rdy_cnt, 1);
    chk("stop_pending_cycles", pend_cnt, 2);

    // brk and STOP together: brk wins, STOP stays pending
    clk_cnt = 0; rdy_cnt = 0; evt_seen = 0;
    exp_code_q.push_back(1); exp_cnt_q.push_back(1);
    send(3'd4);
    for (int i = 0; i < 300 && !evt_seen; i++) begin
      if (clk_cnt >= 1) begin brk = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd5; end
      tick();
    end
    chk("brkstop_evt_seen", evt_seen, 1);
    chk("brkstop_no_accept", rdy_cnt, 0);
    #1;
    chk("brkstop_pending_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    brk = 1'b0;
    chk("brkstop_idle", busy, 0);

    // reset while stalled in RUN_OUT
    clk_cnt = 0; evt_seen = 0;
    send(3'd4);
    for (int i = 0; i < 100 && out_valid !== 1'b1; i++) begin
      c_out_valid = (clk_cnt >= 1);
      c_out = 8'h5a;
      tick();
    end
    c_out_valid = 1'b0;
    chk("rstrun_out_valid", out_valid, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstrun_cmd_ready", cmd_ready, 0);
    tick();
    rst = 1'b0;
    chk("rstrun_busy", busy, 0);
    chk("rstrun_out_valid0", out_valid, 0);
    chk("rstrun_ctrlen", ctrlen, 1);
    chk("rstrun_evt_valid", evt_valid, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("rstrun_no_evt", evt_seen, 0);
    chk("evt_scoreboard_empty", exp_code_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
